// File: rtl/axis_frame_len_filter_if.sv
// AXI-Stream bus bundle (data, valid, ready, last, user) used on both sides of
// axis_frame_len_filter.
interface axis_frame_len_filter_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic                  tuser;

  modport master (
    output tdata,
    output tvalid,
    input  tready,
    output tlast,
    output tuser
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready,
    input  tlast,
    input  tuser
  );
endinterface

// File: rtl/axis_frame_len_filter.sv
// AXI-Stream frame length policer: marks runt/errored frames via tuser on tlast and truncates
// frames at MAX_LEN beats. Define AXIS_LEN_FILTER_STATS_EN to add good/bad frame counters.
module axis_frame_len_filter #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 12,
  parameter int MIN_LEN    = 4,
  parameter int MAX_LEN    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axis_frame_len_filter_if.slave  input_axis,
  axis_frame_len_filter_if.master output_axis,
  output logic                    frame_short,
  output logic                    frame_truncated
`ifdef AXIS_LEN_FILTER_STATS_EN
  ,
  output logic [31:0]             good_frames,
  output logic [31:0]             bad_frames
`endif
);

  localparam logic [LEN_WIDTH-1:0] MIN_N = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_N = LEN_WIDTH'(MAX_LEN);

  typedef enum logic [0:0] {
    ST_PASS    = 1'b0,
    ST_DISCARD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  out_tdata_q, out_tdata_d;
  logic                   out_tvalid_q, out_tvalid_d;
  logic                   out_tlast_q, out_tlast_d;
  logic                   out_tuser_q, out_tuser_d;
  logic                   short_q, short_d;
  logic                   trunc_q, trunc_d;

  logic                   load_en;
  logic                   in_ready;
  logic                   accept;
  logic [LEN_WIDTH-1:0]   beat_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_PASS;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      out_tlast_q  <= 1'b0;
      out_tuser_q  <= 1'b0;
      short_q      <= 1'b0;
      trunc_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      out_tdata_q  <= out_tdata_d;
      out_tvalid_q <= out_tvalid_d;
      out_tlast_q  <= out_tlast_d;
      out_tuser_q  <= out_tuser_d;
      short_q      <= short_d;
      trunc_q      <= trunc_d;
    end
  end

  always_comb begin
    load_en  = output_axis.tready | ~out_tvalid_q;
    // While discarding the tail of a cut frame we swallow beats regardless of the sink.
    in_ready = (state_q == ST_DISCARD) | load_en;
    accept   = input_axis.tvalid & in_ready;
    beat_n   = cnt_q + 1'b1;

    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    out_tdata_d  = out_tdata_q;
    out_tvalid_d = out_tvalid_q;
    out_tlast_d  = out_tlast_q;
    out_tuser_d  = out_tuser_q;
    short_d      = 1'b0;
    trunc_d      = 1'b0;

    if (load_en) begin
      out_tvalid_d = 1'b0;
    end

    case (state_q)
      ST_PASS: begin
        if (accept) begin
          out_tdata_d  = input_axis.tdata;
          out_tvalid_d = 1'b1;
          out_tlast_d  = input_axis.tlast;
          out_tuser_d  = input_axis.tuser | err_q;
          if (input_axis.tlast) begin
            if (beat_n < MIN_N) begin
              out_tuser_d = 1'b1;
              short_d     = 1'b1;
            end
            cnt_d = '0;
            err_d = 1'b0;
          end else if (beat_n == MAX_N) begin
            out_tlast_d = 1'b1;
            out_tuser_d = 1'b1;
            trunc_d     = 1'b1;
            cnt_d       = '0;
            err_d       = 1'b0;
            state_d     = ST_DISCARD;
          end else begin
            cnt_d = beat_n;
            err_d = err_q | input_axis.tuser;
          end
        end
      end
      ST_DISCARD: begin
        if (accept && input_axis.tlast) begin
          state_d = ST_PASS;
        end
      end
      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  assign input_axis.tready  = in_ready;
  assign output_axis.tdata  = out_tdata_q;
  assign output_axis.tvalid = out_tvalid_q;
  assign output_axis.tlast  = out_tlast_q;
  assign output_axis.tuser  = out_tuser_q;
  assign frame_short        = short_q;
  assign frame_truncated    = trunc_q;

`ifdef AXIS_LEN_FILTER_STATS_EN
  logic [31:0] good_q, good_d;
  logic [31:0] bad_q, bad_d;
  logic        load_last;

  // Frames are classified when their final beat enters the output register.
  always_comb begin
    load_last = (state_q == ST_PASS) & accept & out_tlast_d;
    good_d    = good_q;
    bad_d     = bad_q;
    if (load_last) begin
      if (out_tuser_d) begin
        if (bad_q != 32'hFFFF_FFFF) bad_d = bad_q + 32'd1;
      end else begin
        if (good_q != 32'hFFFF_FFFF) good_d = good_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign good_frames = good_q;
  assign bad_frames  = bad_q;
`endif

endmodule

// File: tb/tb_axis_frame_len_filter.sv
// Randomised scoreboard bench for axis_frame_len_filter (MIN_LEN=4, MAX_LEN=8).
module tb_axis_frame_len_filter;
  localparam int DW   = 8;
  localparam int LW   = 12;
  localparam int MINL = 4;
  localparam int MAXL = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    logic          short_p;
    logic          trunc_p;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_short;
  logic frame_truncated;
`ifdef AXIS_LEN_FILTER_STATS_EN
  logic [31:0] good_frames;
  logic [31:0] bad_frames;
`endif

  axis_frame_len_filter_if #(.DATA_WIDTH(DW)) in_if ();
  axis_frame_len_filter_if #(.DATA_WIDTH(DW)) out_if ();

  axis_frame_len_filter #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .MIN_LEN   (MINL),
    .MAX_LEN   (MAXL)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .input_axis     (in_if),
    .output_axis    (out_if),
    .frame_short    (frame_short),
    .frame_truncated(frame_truncated)
`ifdef AXIS_LEN_FILTER_STATS_EN
    ,
    .good_frames    (good_frames),
    .bad_frames     (bad_frames)
`endif
  );

  always #5 clk = ~clk;

  beat_t exp_q[$];
  beat_t mon_e;
  int total = 0;
  int bad = 0;
  int short_seen = 0, trunc_seen = 0;
  int short_exp = 0, trunc_exp = 0;
  int good_exp = 0, bad_exp = 0;
  int sink_mode = 0;  // 0 always ready, 1 toggling, 2 random

  // Monitor: every output transfer is matched against the next expected beat.
  always @(negedge clk) begin
    if (frame_short) short_seen++;
    if (frame_truncated) trunc_seen++;
    if (out_if.tvalid && out_if.tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL beat: unexpected output data=%h last=%b user=%b, required none", out_if.tdata, out_if.tlast, out_if.tuser);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_if.tdata !== mon_e.data || out_if.tlast !== mon_e.last || out_if.tuser !== mon_e.user) begin
          bad++;
          $display("FAIL beat: got data=%h last=%b user=%b, required data=%h last=%b user=%b",
                   out_if.tdata, out_if.tlast, out_if.tuser, mon_e.data, mon_e.last, mon_e.user);
        end
        if (mon_e.short_p) short_exp++;
        if (mon_e.trunc_p) trunc_exp++;
        if (mon_e.last) begin
          total++;
          if (short_seen != short_exp || trunc_seen != trunc_exp) begin
            bad++;
            $display("FAIL pulses: got short=%0d trunc=%0d, required short=%0d trunc=%0d",
                     short_seen, trunc_seen, short_exp, trunc_exp);
          end
        end
      end
    end
  end

  // Sink ready driver.
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
        0:       out_if.tready = 1'b1;
        1:       out_if.tready = ~out_if.tready;
        default: out_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_beat(input logic [DW-1:0] d, input logic l, input logic u);
    logic rdy;
    int w;
    in_if.tdata  = d;
    in_if.tlast  = l;
    in_if.tuser  = u;
    in_if.tvalid = 1'b1;
    rdy = 1'b0;
    w = 0;
    while (!rdy && w < 200) begin
      @(negedge clk);
      rdy = in_if.tready;
      @(posedge clk);
      #1;
      w++;
    end
    in_if.tvalid = 1'b0;
    if (!rdy) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: tready=0 required=1 for data=%h", d);
    end
  endtask

  // Reference model: a frame of len beats is emitted whole if len<=MAXL, else cut to MAXL beats.
  task automatic send_frame(input int len, input logic [DW-1:0] base, input logic [15:0] err_mask, input int gap_max);
    int emit_n;
    logic any_err;
    beat_t e;
    logic [DW-1:0] d;
    emit_n = (len > MAXL) ? MAXL : len;
    any_err = 1'b0;
    for (int i = 0; i < emit_n; i++) begin
      any_err = any_err | err_mask[i];
      e.data    = DW'(base + i);
      e.last    = (i == emit_n - 1);
      e.user    = any_err;
      e.short_p = 1'b0;
      e.trunc_p = 1'b0;
      if (e.last) begin
        if (len > MAXL) begin
          e.user = 1'b1;
          e.trunc_p = 1'b1;
        end else if (len < MINL) begin
          e.user = 1'b1;
          e.short_p = 1'b1;
        end
        if (e.user) bad_exp++;
        else good_exp++;
      end
      exp_q.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      d = DW'(base + i);
      drive_beat(d, (i == len - 1), err_mask[i]);
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 1000) begin
      @(posedge clk);
      #1;
      w++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    total++;
    if (out_if.tvalid !== 1'b0 || out_if.tdata !== '0 || out_if.tlast !== 1'b0 ||
        out_if.tuser !== 1'b0 || frame_short !== 1'b0 || frame_truncated !== 1'b0) begin
      bad++;
      $display("FAIL %s: got valid=%b data=%h last=%b user=%b short=%b trunc=%b, required all 0",
               name, out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser, frame_short, frame_truncated);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int len;
    logic [15:0] em;
    in_if.tdata  = '0;
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
    in_if.tuser  = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle("reset_state");

    send_frame(5, 8'h01, 16'h0000, 0);
    send_frame(2, 8'hA0, 16'h0000, 0);
    send_frame(11, 8'h10, 16'h0000, 0);
    send_frame(6, 8'h30, 16'h0002, 0);
    drain();
    sink_mode = 1;
    send_frame(8, 8'h40, 16'h0000, 0);
    drain();
    sink_mode = 0;
    send_frame(1, 8'h48, 16'h0000, 0);
    send_frame(9, 8'h70, 16'h0000, 1);
    drain();

    // Abandoned frame: three beats then a one-cycle reset.
    for (int i = 0; i < 3; i++) begin
      mon_e.data = DW'(8'h50 + i);
      mon_e.last = 1'b0;
      mon_e.user = 1'b0;
      mon_e.short_p = 1'b0;
      mon_e.trunc_p = 1'b0;
      exp_q.push_back(mon_e);
      drive_beat(DW'(8'h50 + i), 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    good_exp = 0;
    bad_exp = 0;
    check_idle("mid_frame_reset");
    send_frame(4, 8'h60, 16'h0000, 0);
    drain();

    sink_mode = 2;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 12);
      em = 16'h0000;
      for (int b = 0; b < 16; b++) em[b] = ($urandom_range(0, 9) == 0);
      send_frame(len, 8'($urandom_range(0, 255)), em, $urandom_range(0, 2));
    end
    sink_mode = 0;
    drain();

    total++;
    if (short_seen != short_exp || trunc_seen != trunc_exp) begin
      bad++;
      $display("FAIL pulse_totals: got short=%0d trunc=%0d, required short=%0d trunc=%0d",
               short_seen, trunc_seen, short_exp, trunc_exp);
    end
`ifdef AXIS_LEN_FILTER_STATS_EN
    total++;
    if (good_frames != 32'(good_exp) || bad_frames != 32'(bad_exp)) begin
      bad++;
      $display("FAIL stats: got good=%0d bad=%0d, required good=%0d bad=%0d",
               good_frames, bad_frames, good_exp, bad_exp);
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
